reaction_timer_ctrl: RTL
========================

REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, debounced single-cycle start-button pulse.
REQ-004 SHALL have port stop, input, 1, debounced single-cycle stop-button pulse.
REQ-005 SHALL have port tick_1ms, input, 1, single-cycle 1 kHz enable pulse.
REQ-006 SHALL have port led, output, 1, stimulus lamp; high only in TIMING.
REQ-007 SHALL have port rs_en, output, 1, result-show enable to display controller; high in TIMING and DONE.
REQ-008 SHALL have ports rd3, rd2, rd1, rd0, output, 4 each, BCD elapsed ms, rd3 most significant (display shows rd3.rd2rd1rd0 s).
REQ-009 SHALL have port done, output, 1, one-cycle pulse on entry to DONE.

Function
REQ-010 SHALL implement states IDLE, WAIT, TIMING, DONE (plus EARLY, per REQ-024).
REQ-011 IDLE: start -> WAIT, loading delay counter with 2000 + lfsr[9:0] (2000..3023 ms); other inputs ignored.
REQ-012 LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, stepping every clk, seed 16'hACE1.
REQ-013 WAIT: each tick_1ms decrements delay; tick at delay==1 -> TIMING next cycle with BCD cleared to 0000.
REQ-014 TIMING: each tick_1ms increments 4-digit BCD with per-digit carry 9->0; led=1.
REQ-015 TIMING: stop -> DONE, BCD frozen at current value; stop and tick in same cycle: stop wins, tick not applied.
REQ-016 TIMING: tick at 9999 -> BCD holds 9999 (saturate), -> DONE.
REQ-017 DONE: BCD held, rs_en=1, led=0; start -> WAIT with new delay (REQ-011), rs_en=0 from next cycle.
REQ-018 start in WAIT or TIMING SHALL be ignored; stop in IDLE or DONE ignored.
REQ-019 done SHALL be high exactly one cycle, the first cycle in DONE.
REQ-020 Outputs SHALL be registered; state change visible one cycle after qualifying input.

Reset
REQ-021 rst SHALL force IDLE, led=0, rs_en=0, done=0, rd3..rd0=0, delay=0, lfsr=16'hACE1, from any state including mid-TIMING.
REQ-022 rst SHALL take priority over start, stop, tick_1ms in the same cycle.

Configuration
REQ-023 Macro RT_EARLY_DETECT_EN SHALL control early-press detection.
REQ-024 Defined: stop in WAIT -> EARLY; rd3..rd0=9,9,9,9, rs_en=1, led=0, done pulses; start in EARLY -> WAIT as from DONE.
REQ-025 Undefined: stop in WAIT ignored; EARLY state absent from RTL.

Structure
REQ-026 Package rt_pkg SHALL hold state enum rt_state_t, MIN_DELAY_MS=2000, LFSR_SEED=16'hACE1, BCD_MAX digit constant 4'd9.
REQ-027 Sub-module bcd_counter4 SHALL implement 4-digit BCD counter with clear, enable, saturate-at-9999 and sat flag.

Verification
REQ-028 rst, start at cycle 10 with lfsr[9:0]=0 -> led rises after exactly 2000 ticks, rs_en=1, rd=0000.
REQ-029 In TIMING, 347 ticks then stop -> rd=0,3,4,7, done one cycle, led=0; further ticks leave rd unchanged.
REQ-030 In TIMING, 10000 ticks with no stop -> rd saturates 9,9,9,9, DONE entered, done pulses once.
REQ-031 stop and tick same cycle at rd=0129 -> rd stays 0129; DONE.
REQ-032 With RT_EARLY_DETECT_EN, stop 500 ticks into WAIT -> rd=9999, rs_en=1, led never high; without macro -> stays WAIT, led rises on schedule.
REQ-033 rst asserted mid-TIMING at rd=0050 -> next cycle IDLE, all outputs 0, lfsr=16'hACE1.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction timer controller.
// RT_EARLY_DETECT_EN adds the EARLY state for a stop pressed before the lamp lights.
package rt_pkg;

`ifdef RT_EARLY_DETECT_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3,
        ST_EARLY  = 3'd4
    } rt_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3
    } rt_state_t;
`endif

    localparam int unsigned MIN_DELAY_MS = 2000;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [3:0]  BCD_MAX      = 4'd9;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter: clear, enable, load-to-max and saturation at 9999.
module bcd_counter4
    import rt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       set_max,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       sat
);

    logic [3:0] d3_q, d2_q, d1_q, d0_q;
    logic [3:0] d3_d, d2_d, d1_d, d0_d;

    assign sat = (d3_q == BCD_MAX) && (d2_q == BCD_MAX) &&
                 (d1_q == BCD_MAX) && (d0_q == BCD_MAX);

    always_comb begin
        d3_d = d3_q;
        d2_d = d2_q;
        d1_d = d1_q;
        d0_d = d0_q;
        // Ripple carry only while below 9999, so the top digit never wraps.
        if (en && !sat) begin
            if (d0_q == BCD_MAX) begin
                d0_d = 4'd0;
                if (d1_q == BCD_MAX) begin
                    d1_d = 4'd0;
                    if (d2_q == BCD_MAX) begin
                        d2_d = 4'd0;
                        d3_d = d3_q + 4'd1;
                    end else begin
                        d2_d = d2_q + 4'd1;
                    end
                end else begin
                    d1_d = d1_q + 4'd1;
                end
            end else begin
                d0_d = d0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d3_q <= 4'd0;
            d2_q <= 4'd0;
            d1_q <= 4'd0;
            d0_q <= 4'd0;
        end else if (set_max) begin
            d3_q <= BCD_MAX;
            d2_q <= BCD_MAX;
            d1_q <= BCD_MAX;
            d0_q <= BCD_MAX;
        end else if (clr) begin
            d3_q <= 4'd0;
            d2_q <= 4'd0;
            d1_q <= 4'd0;
            d0_q <= 4'd0;
        end else begin
            d3_q <= d3_d;
            d2_q <= d2_d;
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    assign d3 = d3_q;
    assign d2 = d2_q;
    assign d1 = d1_q;
    assign d0 = d0_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer: random 2.000-3.023 s delay, then counts ms until stop (max 9.999 s).
// Define RT_EARLY_DETECT_EN to flag a stop pressed during the delay as 9999.
module reaction_timer_ctrl
    import rt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       tick_1ms,
    output logic       led,
    output logic       rs_en,
    output logic [3:0] rd3,
    output logic [3:0] rd2,
    output logic [3:0] rd1,
    output logic [3:0] rd0,
    output logic       done
);

    rt_state_t   state_q;
    logic [15:0] lfsr_q;
    logic [11:0] delay_q;
    logic        led_q;
    logic        rs_en_q;
    logic        done_q;

    logic        can_start;
    logic        bcd_clr;
    logic        bcd_en;
    logic        bcd_set;
    logic        bcd_sat;

    always_comb begin
        can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
`ifdef RT_EARLY_DETECT_EN
        can_start = can_start || (state_q == ST_EARLY);
`endif
    end

    // Stop outranks a coincident tick while timing, so the count freezes as seen.
    assign bcd_en  = (state_q == ST_TIMING) && tick_1ms && !stop;
    assign bcd_clr = (state_q == ST_WAIT) && tick_1ms && (delay_q == 12'd1);
`ifdef RT_EARLY_DETECT_EN
    assign bcd_set = (state_q == ST_WAIT) && stop;
`else
    assign bcd_set = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            delay_q <= 12'd0;
            led_q   <= 1'b0;
            rs_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            done_q <= 1'b0;
            if (can_start && start) begin
                state_q <= ST_WAIT;
                delay_q <= 12'(MIN_DELAY_MS) + {2'b00, lfsr_q[9:0]};
                led_q   <= 1'b0;
                rs_en_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: ;
                    ST_WAIT: begin
`ifdef RT_EARLY_DETECT_EN
                        if (stop) begin
                            state_q <= ST_EARLY;
                            rs_en_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else
`endif
                        if (tick_1ms) begin
                            delay_q <= delay_q - 12'd1;
                            if (delay_q == 12'd1) begin
                                state_q <= ST_TIMING;
                                led_q   <= 1'b1;
                                rs_en_q <= 1'b1;
                            end
                        end
                    end
                    ST_TIMING: begin
                        if (stop || (tick_1ms && bcd_sat)) begin
                            state_q <= ST_DONE;
                            led_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
`ifdef RT_EARLY_DETECT_EN
                    ST_EARLY: ;
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        led_q   <= 1'b0;
                        rs_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    bcd_counter4 u_bcd (
        .clk     (clk),
        .rst     (rst),
        .clr     (bcd_clr),
        .en      (bcd_en),
        .set_max (bcd_set),
        .d3      (rd3),
        .d2      (rd2),
        .d1      (rd1),
        .d0      (rd0),
        .sat     (bcd_sat)
    );

    assign led   = led_q;
    assign rs_en = rs_en_q;
    assign done  = done_q;

endmodule
